// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of Data_mem: word accesses, read-modify-write
// sub-word stores, lane extraction/extension of loads, and misalignment/illegal-size flagging.
module mem_access_unit #(
  parameter int ADDR_W       = 32,
  parameter int WORD_INDEXED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_re,
  output logic              dm_we,
  input  logic [31:0]       dm_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_r, state_nx_s;
  logic [1:0]          off_r, size_r;
  logic                signed_r, we_r;
  logic [15:0]         wdata_r;
  logic                lat_en_s, err_s;

  logic                req_ready_r, resp_valid_r, resp_err_r, dm_re_r, dm_we_r;
  logic [31:0]         resp_rdata_r, dm_wdata_r;
  logic [ADDR_W-1:0]   dm_addr_r;

  logic                req_ready_nx_s, resp_valid_nx_s, resp_err_nx_s, dm_re_nx_s, dm_we_nx_s;
  logic [31:0]         resp_rdata_nx_s, dm_wdata_nx_s;
  logic [ADDR_W-1:0]   dm_addr_nx_s;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    if (WORD_INDEXED != 0) begin
      r = {2'b00, a[ADDR_W-1:2]};
    end else begin
      r = {a[ADDR_W-1:2], 2'b00};
    end
    return r;
  endfunction

  // Move the addressed lane down to bit 0 and extend it; words pass through.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) begin
          r[31:16] = d;
        end else begin
          r[15:0] = d;
        end
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Request legality: illegal size or misaligned half/word.
  always_comb begin
    err_s = (req_size == 2'b11) ||
            ((req_size == SZ_HALF) && req_addr[0]) ||
            ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nx_s      = state_r;
    lat_en_s        = 1'b0;
    req_ready_nx_s  = 1'b0;
    resp_valid_nx_s = 1'b0;
    resp_err_nx_s   = 1'b0;
    resp_rdata_nx_s = 32'h0000_0000;
    dm_re_nx_s      = 1'b0;
    dm_we_nx_s      = 1'b0;
    dm_addr_nx_s    = dm_addr_r;
    dm_wdata_nx_s   = dm_wdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          lat_en_s     = 1'b1;
          dm_addr_nx_s = word_addr(req_addr);
          if (err_s) begin
            state_nx_s      = RESP;
            resp_valid_nx_s = 1'b1;
            resp_err_nx_s   = 1'b1;
          end else if (!req_we || (req_size != SZ_WORD)) begin
            state_nx_s = RD;
            dm_re_nx_s = 1'b1;
          end else begin
            state_nx_s    = WR;
            dm_we_nx_s    = 1'b1;
            dm_wdata_nx_s = req_wdata;
          end
        end else begin
          req_ready_nx_s = 1'b1;
        end
      end
      RD: begin
        if (we_r) begin
          state_nx_s    = WR;
          dm_we_nx_s    = 1'b1;
          dm_wdata_nx_s = store_merge(dm_rdata, wdata_r, size_r, off_r);
        end else begin
          state_nx_s      = RESP;
          resp_valid_nx_s = 1'b1;
          resp_rdata_nx_s = load_extract(dm_rdata, size_r, off_r, signed_r);
        end
      end
      WR: begin
        state_nx_s      = RESP;
        resp_valid_nx_s = 1'b1;
      end
      RESP: begin
        state_nx_s     = IDLE;
        req_ready_nx_s = 1'b1;
      end
      default: begin
        state_nx_s     = IDLE;
        req_ready_nx_s = 1'b1;
      end
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      off_r        <= 2'b00;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      we_r         <= 1'b0;
      wdata_r      <= 16'h0000;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      dm_re_r      <= 1'b0;
      dm_we_r      <= 1'b0;
      dm_addr_r    <= '0;
      dm_wdata_r   <= 32'h0000_0000;
    end else begin
      state_r      <= state_nx_s;
      if (lat_en_s) begin
        off_r    <= req_addr[1:0];
        size_r   <= req_size;
        signed_r <= req_signed;
        we_r     <= req_we;
        wdata_r  <= req_wdata[15:0];
      end
      req_ready_r  <= req_ready_nx_s;
      resp_valid_r <= resp_valid_nx_s;
      resp_err_r   <= resp_err_nx_s;
      resp_rdata_r <= resp_rdata_nx_s;
      dm_re_r      <= dm_re_nx_s;
      dm_we_r      <= dm_we_nx_s;
      dm_addr_r    <= dm_addr_nx_s;
      dm_wdata_r   <= dm_wdata_nx_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign dm_re      = dm_re_r;
  assign dm_we      = dm_we_r;
  assign dm_addr    = dm_addr_r;
  assign dm_wdata   = dm_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small behavioural Data_mem.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_rdata;

  logic [31:0] mem [0:15];
  int n_checks = 0;
  int n_fail = 0;

  mem_access_unit #(.ADDR_W(32), .WORD_INDEXED(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_re(dm_re), .dm_we(dm_we), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data_mem: combinational read while dm_re, write on the rising edge.
  assign dm_rdata = dm_re ? mem[dm_addr[3:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[3:0]] <= dm_wdata;
  end

  // Issue one request and observe until resp_valid (bounded); returns observations only.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int re_cnt, output int we_cnt,
                        output logic [31:0] we_addr, output logic [31:0] we_data);
    lat = 0; rdata = 32'hX; err = 1'bX; re_cnt = 0; we_cnt = 0;
    we_addr = 32'h0; we_data = 32'h0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (dm_re) re_cnt++;
      if (dm_we) begin we_cnt++; we_addr = dm_addr; we_data = dm_wdata; end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_checks++; if ({dm_re, dm_we, resp_err} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {dm_re, dm_we, resp_err}); end
    n_checks++; if ({dm_addr, dm_wdata, resp_rdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {dm_addr, dm_wdata, resp_rdata}); end
  endtask

  task automatic test_word();
    int lat, rc, wc; logic [31:0] rd, wa, wd; logic err;
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h2341_A214, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
    n_checks++; if (wc !== 1 || rc !== 0) begin n_fail++; $display("FAIL sw_strobes got we=%0d re=%0d want we=1 re=0", wc, rc); end
    n_checks++; if (wa !== 32'h2 || wd !== 32'h2341_A214) begin n_fail++; $display("FAIL sw_bus got addr=%h data=%h want 2/2341a214", wa, wd); end
    n_checks++; if (err !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", err, rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (lat !== 2 || rc !== 1 || wc !== 0) begin n_fail++; $display("FAIL lw_timing got lat=%0d re=%0d we=%0d want 2/1/0", lat, rc, wc); end
    n_checks++; if (rd !== 32'h2341_A214 || err !== 1'b0) begin n_fail++; $display("FAIL lw_data got %h err=%b want 2341a214", rd, err); end
  endtask

  task automatic test_load_sweep();
    logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [5] = '{32'h9, 32'h9, 32'h8, 32'h8, 32'hA};
    logic [31:0] ex [5] = '{32'hFFFF_FFA2, 32'h0000_00A2, 32'hFFFF_A214, 32'h0000_A214, 32'h0000_2341};
    int lat, rc, wc; logic [31:0] rd, wa, wd; logic err;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, err, rc, wc, wa, wd);
      n_checks++; if (rd !== ex[i] || lat !== 2 || err !== 1'b0) begin n_fail++; $display("FAIL load_sweep[%0d] got %h lat=%0d err=%b want %h lat=2", i, rd, lat, err, ex[i]); end
    end
  endtask

  task automatic test_subword_store();
    int lat, rc, wc; logic [31:0] rd, wa, wd; logic err;
    do_req(1'b1, 2'b00, 1'b0, 32'hB, 32'h0000_0055, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (lat !== 3 || rc !== 1 || wc !== 1) begin n_fail++; $display("FAIL sb_timing got lat=%0d re=%0d we=%0d want 3/1/1", lat, rc, wc); end
    n_checks++; if (wd !== 32'h5541_A214 || wa !== 32'h2) begin n_fail++; $display("FAIL sb_wdata got %h addr=%h want 5541a214/2", wd, wa); end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (rd !== 32'h5541_A214) begin n_fail++; $display("FAIL sb_readback got %h want 5541a214", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h8, 32'hFFFF_BEEF, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (wd !== 32'h5541_BEEF || lat !== 3) begin n_fail++; $display("FAIL sh_wdata got %h lat=%0d want 5541beef lat=3", wd, lat); end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (rd !== 32'h5541_BEEF) begin n_fail++; $display("FAIL sh_readback got %h want 5541beef", rd); end
  endtask

  task automatic test_errors();
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h6, 32'h9, 32'h8};
    int lat, rc, wc; logic [31:0] rd, wa, wd; logic err;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, sz[i], 1'b1, ad[i], 32'h0, lat, rd, err, rc, wc, wa, wd);
      n_checks++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL err[%0d] got err=%b rdata=%h lat=%0d want 1/0/1", i, err, rd, lat); end
      n_checks++; if (rc !== 0 || wc !== 0) begin n_fail++; $display("FAIL err_strobes[%0d] got re=%0d we=%0d want 0/0", i, rc, wc); end
    end
    do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'h1234_5678, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (err !== 1'b1 || wc !== 0 || rc !== 0) begin n_fail++; $display("FAIL err_store got err=%b we=%0d re=%0d want 1/0/0", err, wc, rc); end
  endtask

  task automatic test_reset_mid();
    int lat, rc, wc, bad; logic [31:0] rd, wa, wd; logic err;
    bad = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h8; req_wdata = 32'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (dm_re !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rd got dm_re=%b want 1", dm_re); end
    rst = 1'b1;
    @(posedge clk); #1;
    if (dm_we !== 1'b0 || resp_valid !== 1'b0) bad++;
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
    for (int c = 0; c < 4; c++) begin
      if (dm_we !== 1'b0 || resp_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d strobe cycles want 0", bad); end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, err, rc, wc, wa, wd);
    n_checks++; if (rd !== 32'h5541_BEEF) begin n_fail++; $display("FAIL rst_mid_mem got %h want 5541beef", rd); end
  endtask

  task automatic test_back_to_back();
    int first, second, nresp, nre; logic prev_ready; logic [31:0] r1, r2;
    first = 0; second = 0; nresp = 0; nre = 0; prev_ready = 1'b0; r1 = 32'h0; r2 = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h8;
    @(posedge clk); #1;
    req_size = 2'b00; req_addr = 32'h9;
    for (int c = 1; c <= 8; c++) begin
      if (prev_ready) req_valid = 1'b0;
      prev_ready = req_ready;
      if (dm_re) nre++;
      if (resp_valid) begin
        nresp++;
        if (nresp == 1) begin first = c; r1 = resp_rdata; end
        else begin second = c; r2 = resp_rdata; end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_checks++; if (first !== 2 || second !== 5 || nresp !== 2) begin n_fail++; $display("FAIL b2b_timing got resp at %0d,%0d n=%0d want 2,5 n=2", first, second, nresp); end
    n_checks++; if (nre !== 2) begin n_fail++; $display("FAIL b2b_reads got %0d want 2", nre); end
    n_checks++; if (r1 !== 32'h5541_BEEF || r2 !== 32'h0000_00BE) begin n_fail++; $display("FAIL b2b_data got %h,%h want 5541beef,000000be", r1, r2); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_load_sweep();
    test_subword_store();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
